// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel-rate divider, raster counters, visible-area
// decode and a registered pin stage that delays syncs and colour by one pixel together.
module vga_sync_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pix_en,
  output logic        frame_tick,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_LO = 10'(H_START);
  localparam logic [9:0] H_ACT_HI = 10'(H_START + H_ACTIVE - 1);
  localparam logic [9:0] V_ACT_LO = 10'(V_START);
  localparam logic [9:0] V_ACT_HI = 10'(V_START + V_ACTIVE - 1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [11:0]      rgb_q, rgb_d;

  logic h_last, v_last, hs_raw, vs_raw, pix_en_w, bright_w;

  assign pix_en_w = (div_q == DIV_LAST);
  assign h_last   = (h_q == H_LAST);
  assign v_last   = (v_q == V_LAST);
  assign bright_w = (h_q >= H_ACT_LO) && (h_q <= H_ACT_HI) &&
                    (v_q >= V_ACT_LO) && (v_q <= V_ACT_HI);
  assign hs_raw   = (h_q < H_SYNC_W);
  assign vs_raw   = (v_q < V_SYNC_W);

  // Divider free-runs; with CLK_DIV=1 it sits at 0 and the strobe is constant.
  always_comb begin
    div_d = div_q + 1'b1;
    if (pix_en_w) div_d = '0;
  end

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en_w) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Pin stage: syncs and colour see the same one-pixel delay.
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    if (pix_en_w) begin
      hsync_d = ~hs_raw;
      vsync_d = ~vs_raw;
      rgb_d   = bright_w ? rgb_in : 12'h000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= '0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hCount     = h_q;
  assign vCount     = v_q;
  assign bright     = bright_w;
  assign pix_en     = pix_en_w;
  assign frame_tick = pix_en_w & h_last & v_last;
  assign hSync      = hsync_q;
  assign vSync      = vsync_q;
  assign vga_r      = rgb_q[11:8];
  assign vga_g      = rgb_q[7:4];
  assign vga_b      = rgb_q[3:0];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance for divider/line/reset timing and a
// shrunken-raster instance (CLK_DIV=1, 13x9) for table-driven frame and pixel alignment.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Full-size instance
  logic        rst_a;
  logic [11:0] rgb_a;
  logic [9:0]  h_a, v_a;
  logic        br_a, pix_a, ft_a, hs_a, vs_a;
  logic [3:0]  r_a, g_a, b_a;

  vga_sync_gen dut_a (
    .clk(clk), .rst(rst_a), .rgb_in(rgb_a),
    .hCount(h_a), .vCount(v_a), .bright(br_a), .pix_en(pix_a), .frame_tick(ft_a),
    .hSync(hs_a), .vSync(vs_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
  );

  // Small raster: H 2+3+6+2=13 (active 5..10), V 2+2+4+1=9 (active 4..7)
  logic        rst_b;
  logic [11:0] rgb_b;
  logic [9:0]  h_b, v_b;
  logic        br_b, pix_b, ft_b, hs_b, vs_b;
  logic [3:0]  r_b, g_b, b_b;

  vga_sync_gen #(
    .CLK_DIV(1), .H_SYNC(2), .H_BP(3), .H_ACTIVE(6), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_ACTIVE(4), .V_FP(1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .rgb_in(rgb_b),
    .hCount(h_b), .vCount(v_b), .bright(br_b), .pix_en(pix_b), .frame_tick(ft_b),
    .hSync(hs_b), .vSync(vs_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
  );

  typedef struct {
    int          adv;
    logic [11:0] rgb;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        br;
    logic        hs;
    logic        vs;
    logic [11:0] pin;
    logic        ft;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance to the next pixel strobe of the full-size instance, bounded.
  task automatic wait_pix_a(output bit ok);
    ok = 1'b0;
    step();
    for (int n = 0; n < 8; n++) begin
      if (pix_a) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) chk("wait_pix_a_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int cnt, hmis, vmis, hs_low, vs_low, ft_cnt, pix_cnt;
    logic hs_k0, hs_k1, hs_k96, hs_k97, vs_k799;

    rst_a = 1'b1; rst_b = 1'b1;
    rgb_a = 12'hF00; rgb_b = 12'h000;

    vecs[0]  = '{0,  12'h000, 10'd0,  10'd0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0};
    vecs[1]  = '{1,  12'h000, 10'd1,  10'd0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0};
    vecs[2]  = '{1,  12'h000, 10'd2,  10'd0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0};
    vecs[3]  = '{1,  12'h000, 10'd3,  10'd0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0};
    vecs[4]  = '{10, 12'h000, 10'd0,  10'd1, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0};
    vecs[5]  = '{13, 12'h000, 10'd0,  10'd2, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0};
    vecs[6]  = '{13, 12'h000, 10'd0,  10'd3, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0};
    vecs[7]  = '{5,  12'hF00, 10'd5,  10'd3, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0};
    vecs[8]  = '{13, 12'hF00, 10'd5,  10'd4, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0};
    vecs[9]  = '{1,  12'hF00, 10'd6,  10'd4, 1'b1, 1'b1, 1'b1, 12'hF00, 1'b0};
    vecs[10] = '{5,  12'hF00, 10'd11, 10'd4, 1'b0, 1'b1, 1'b1, 12'hF00, 1'b0};
    vecs[11] = '{1,  12'hF00, 10'd12, 10'd4, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0};
    vecs[12] = '{1,  12'h5A3, 10'd0,  10'd5, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0};
    vecs[13] = '{6,  12'h5A3, 10'd6,  10'd5, 1'b1, 1'b1, 1'b1, 12'h5A3, 1'b0};
    vecs[14] = '{30, 12'h5A3, 10'd10, 10'd7, 1'b1, 1'b1, 1'b1, 12'h5A3, 1'b0};
    vecs[15] = '{1,  12'h5A3, 10'd11, 10'd7, 1'b0, 1'b1, 1'b1, 12'h5A3, 1'b0};
    vecs[16] = '{14, 12'h5A3, 10'd12, 10'd8, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1};
    vecs[17] = '{1,  12'h5A3, 10'd0,  10'd0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0};
    vecs[18] = '{1,  12'h5A3, 10'd1,  10'd0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0};

    repeat (2) step();

    // Reset state and first strobe latency, CLK_DIV=4
    rst_a = 1'b0;
    chk("a_rst_h", 32'(h_a), 32'd0);
    chk("a_rst_v", 32'(v_a), 32'd0);
    chk("a_rst_hs", 32'(hs_a), 32'd1);
    chk("a_rst_vs", 32'(vs_a), 32'd1);
    chk("a_rst_pin", 32'({r_a, g_a, b_a}), 32'd0);
    chk("a_rst_ft", 32'(ft_a), 32'd0);
    chk("a_rst_pix", 32'(pix_a), 32'd0);
    step(); chk("a_pix_clk1", 32'(pix_a), 32'd0);
    step(); chk("a_pix_clk2", 32'(pix_a), 32'd0);
    step(); chk("a_pix_clk3", 32'(pix_a), 32'd1);
    chk("a_h_before_first", 32'(h_a), 32'd0);
    step(); chk("a_h_after_first", 32'(h_a), 32'd1);
    chk("a_pix_clk4", 32'(pix_a), 32'd0);

    cnt = 0;
    repeat (400) begin
      step();
      if (pix_a) cnt++;
    end
    chk("a_pix_duty", 32'(cnt), 32'd100);
    chk("a_h_after_duty", 32'(h_a), 32'd101);

    // One full line from a fresh reset
    rst_a = 1'b1; step(); rst_a = 1'b0;
    hmis = 0; vmis = 0; hs_low = 0;
    hs_k0 = 1'b0; hs_k1 = 1'b1; hs_k96 = 1'b1; hs_k97 = 1'b0; vs_k799 = 1'b1;
    for (int k = 0; k < 800; k++) begin
      wait_pix_a(ok);
      if (!ok) break;
      if (h_a !== 10'(k)) hmis++;
      if (v_a !== 10'd0) vmis++;
      if (!hs_a) hs_low++;
      if (k == 0)   hs_k0 = hs_a;
      if (k == 1)   hs_k1 = hs_a;
      if (k == 96)  hs_k96 = hs_a;
      if (k == 97)  hs_k97 = hs_a;
      if (k == 799) vs_k799 = vs_a;
    end
    chk("a_line_h_seq", 32'(hmis), 32'd0);
    chk("a_line_v_hold", 32'(vmis), 32'd0);
    chk("a_hsync_low_strobes", 32'(hs_low), 32'd96);
    chk("a_hs_at_h0", 32'(hs_k0), 32'd1);
    chk("a_hs_at_h1", 32'(hs_k1), 32'd0);
    chk("a_hs_at_h96", 32'(hs_k96), 32'd0);
    chk("a_hs_at_h97", 32'(hs_k97), 32'd1);
    chk("a_vs_in_line0", 32'(vs_k799), 32'd0);
    wait_pix_a(ok);
    chk("a_line_wrap_h", 32'(h_a), 32'd0);
    chk("a_line_wrap_v", 32'(v_a), 32'd1);
    chk("a_hs_after_799", 32'(hs_a), 32'd1);

    // Mid-line asynchronous reset
    for (int n = 0; n < 1000 && h_a != 10'd400; n++) wait_pix_a(ok);
    chk("a_reach_400", 32'(h_a), 32'd400);
    rst_a = 1'b1;
    #1;
    chk("a_async_h", 32'(h_a), 32'd0);
    chk("a_async_v", 32'(v_a), 32'd0);
    chk("a_async_hs", 32'(hs_a), 32'd1);
    chk("a_async_vs", 32'(vs_a), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b0;
    repeat (3) step();
    chk("a_resume_pix", 32'(pix_a), 32'd1);
    chk("a_resume_h", 32'(h_a), 32'd0);
    step();
    chk("a_resume_h1", 32'(h_a), 32'd1);
    chk("a_resume_v", 32'(v_a), 32'd0);

    // Small raster, CLK_DIV=1: table of raster positions and pin values
    rst_b = 1'b0;
    for (int i = 0; i < 19; i++) begin
      rgb_b = vecs[i].rgb;
      repeat (vecs[i].adv) step();
      chk($sformatf("b_vec%0d_h", i), 32'(h_b), 32'(vecs[i].h));
      chk($sformatf("b_vec%0d_v", i), 32'(v_b), 32'(vecs[i].v));
      chk($sformatf("b_vec%0d_bright", i), 32'(br_b), 32'(vecs[i].br));
      chk($sformatf("b_vec%0d_hs", i), 32'(hs_b), 32'(vecs[i].hs));
      chk($sformatf("b_vec%0d_vs", i), 32'(vs_b), 32'(vecs[i].vs));
      chk($sformatf("b_vec%0d_pin", i), 32'({r_b, g_b, b_b}), 32'(vecs[i].pin));
      chk($sformatf("b_vec%0d_ft", i), 32'(ft_b), 32'(vecs[i].ft));
    end

    // One frame window (117 clk): tick count, sync widths, strobe always high
    ft_cnt = 0; vs_low = 0; hs_low = 0; pix_cnt = 0;
    repeat (117) begin
      step();
      if (ft_b) ft_cnt++;
      if (!vs_b) vs_low++;
      if (!hs_b) hs_low++;
      if (pix_b) pix_cnt++;
    end
    chk("b_ft_per_frame", 32'(ft_cnt), 32'd1);
    chk("b_vs_low_clks", 32'(vs_low), 32'd26);
    chk("b_hs_low_clks", 32'(hs_low), 32'd18);
    chk("b_pix_const", 32'(pix_cnt), 32'd117);

    // Frame tick period
    cnt = 0;
    for (int n = 0; n < 200 && !ft_b; n++) step();
    chk("b_ft_found", 32'(ft_b), 32'd1);
    step();
    for (int n = 0; n < 200 && !ft_b; n++) begin
      step();
      cnt++;
    end
    chk("b_ft_period", 32'(cnt + 1), 32'd117);

    // Mid-frame asynchronous reset on the small raster
    for (int n = 0; n < 200 && !(h_b == 10'd6 && v_b == 10'd5); n++) step();
    chk("b_reach_6_5", 32'({h_b, v_b}), 32'({10'd6, 10'd5}));
    rst_b = 1'b1;
    #1;
    chk("b_async_h", 32'(h_b), 32'd0);
    chk("b_async_v", 32'(v_b), 32'd0);
    chk("b_async_hs", 32'(hs_b), 32'd1);
    chk("b_async_vs", 32'(vs_b), 32'd1);
    chk("b_async_pin", 32'({r_b, g_b, b_b}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b0;
    step();
    chk("b_resume_h", 32'(h_b), 32'd1);
    chk("b_resume_v", 32'(v_b), 32'd0);
    chk("b_resume_hs", 32'(hs_b), 32'd0);
    chk("b_resume_vs", 32'(vs_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
